// File: rtl/i3c_reg_file_if.sv
// Host-side byte bus of the I3C HDR register file: write/read strobes, address, data and read strobe echo.
interface i3c_reg_file_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_wr;
  logic [7:0]        data_rd;
  logic              ser_rx_tx;

  modport master (output wr_en, rd_en, addr, data_wr, input  data_rd, ser_rx_tx);
  modport slave  (input  wr_en, rd_en, addr, data_wr, output data_rd, ser_rx_tx);
endinterface

// File: rtl/i3c_reg_file.sv
// Byte-addressed command descriptor register file of the I3C HDR controller.
// Define REGF_DESC_LATCH_EN to register all descriptor decodes (one extra cycle of lag).
module i3c_reg_file #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              i_regf_clk,
  input  logic              i_regf_rst_n,
  i3c_reg_file_if.slave     regf_bus,
  input  logic [ADDR_W-1:0] i_engine_configuration,
  output logic [2:0]        o_cccnt_CMD_ATTR,
  output logic [3:0]        o_engine_TID,
  output logic [7:0]        o_ccc_CMD,
  output logic              o_engine_CP,
  output logic [4:0]        o_cccnt_DEV_INDEX,
  output logic [2:0]        o_frmcnt_DTT,
  output logic [2:0]        o_engine_MODE,
  output logic              o_cccnt_RnW,
  output logic              o_cccnt_WROC,
  output logic              o_cccnt_TOC,
  output logic [15:0]       o_frmcnt_data_len,
  output logic [15:0]       o_regf_num_frames
);
  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]  cmd_attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [4:0]  dev_index;
    logic [2:0]  dtt;
    logic [2:0]  mode;
    logic        rnw;
    logic        wroc;
    logic        toc;
    logic [15:0] data_len;
    logic [15:0] num_frames;
  } desc_t;

  logic [7:0] mem [DEPTH];
  logic       wr_hit, rd_hit;

  assign wr_hit = {1'b0, regf_bus.addr} < DEPTH_L;
  assign rd_hit = wr_hit;

  always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
    if (!i_regf_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      regf_bus.data_rd   <= 8'h00;
      regf_bus.ser_rx_tx <= 1'b0;
    end else begin
      if (regf_bus.wr_en && wr_hit) mem[regf_bus.addr[IDX_W-1:0]] <= regf_bus.data_wr;
      // A simultaneous write wins; the read is dropped and data_rd holds.
      if (regf_bus.rd_en && !regf_bus.wr_en) begin
        regf_bus.data_rd   <= rd_hit ? mem[regf_bus.addr[IDX_W-1:0]] : 8'h00;
        regf_bus.ser_rx_tx <= 1'b1;
      end else begin
        regf_bus.ser_rx_tx <= 1'b0;
      end
    end
  end

  // Descriptor bytes B+k, address wrapping at 2^ADDR_W; bytes 4 and 5 are reserved.
  logic [7:0] desc_b [8];
  for (genvar k = 0; k < 8; k++) begin : g_desc
    logic [ADDR_W-1:0] a;
    assign a = i_engine_configuration + ADDR_W'(k);
    if (k == 4 || k == 5) begin : g_rsvd
      assign desc_b[k] = 8'h00;
    end else begin : g_byte
      assign desc_b[k] = ({1'b0, a} < DEPTH_L) ? mem[a[IDX_W-1:0]] : 8'h00;
    end
  end

  logic [31:0] w0;
  logic [15:0] len;
  desc_t       d_comb, d_out;
  logic        unused_bits;

  assign w0          = {desc_b[3], desc_b[2], desc_b[1], desc_b[0]};
  assign len         = {desc_b[7], desc_b[6]};
  assign unused_bits = ^{w0[22:21], desc_b[4], desc_b[5]};

  always_comb begin
    d_comb            = '0;
    d_comb.cmd_attr   = w0[2:0];
    d_comb.tid        = w0[6:3];
    d_comb.cmd        = w0[14:7];
    d_comb.cp         = w0[15];
    d_comb.dev_index  = w0[20:16];
    d_comb.dtt        = w0[25:23];
    d_comb.mode       = w0[28:26];
    d_comb.rnw        = w0[29];
    d_comb.wroc       = w0[30];
    d_comb.toc        = w0[31];
    d_comb.data_len   = len;
    d_comb.num_frames = 16'(({1'b0, len} + 17'd1) >> 1);
  end

`ifdef REGF_DESC_LATCH_EN
  always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
    if (!i_regf_rst_n) d_out <= '0;
    else               d_out <= d_comb;
  end
`else
  assign d_out = d_comb;
`endif

  assign o_cccnt_CMD_ATTR  = d_out.cmd_attr;
  assign o_engine_TID      = d_out.tid;
  assign o_ccc_CMD         = d_out.cmd;
  assign o_engine_CP       = d_out.cp;
  assign o_cccnt_DEV_INDEX = d_out.dev_index;
  assign o_frmcnt_DTT      = d_out.dtt;
  assign o_engine_MODE     = d_out.mode;
  assign o_cccnt_RnW       = d_out.rnw;
  assign o_cccnt_WROC      = d_out.wroc;
  assign o_cccnt_TOC       = d_out.toc;
  assign o_frmcnt_data_len = d_out.data_len;
  assign o_regf_num_frames = d_out.num_frames;
endmodule

// File: tb/tb_i3c_reg_file.sv
// Scoreboard bench for i3c_reg_file: byte-array reference model, read queue, per-cycle decode monitor.
module tb_i3c_reg_file;
  typedef struct packed {
    logic [2:0]  cmd_attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [4:0]  dev_index;
    logic [2:0]  dtt;
    logic [2:0]  mode;
    logic        rnw;
    logic        wroc;
    logic        toc;
    logic [15:0] data_len;
    logic [15:0] num_frames;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cfg = '0;
  logic [2:0]  cmd_attr, dtt, mode;
  logic [3:0]  tid;
  logic [7:0]  cmd;
  logic        cp, rnw, wroc, toc;
  logic [4:0]  dev_index;
  logic [15:0] data_len, num_frames;

  i3c_reg_file_if #(.ADDR_W(12)) bus ();

  i3c_reg_file #(.ADDR_W(12), .DEPTH(1024)) dut (
    .i_regf_clk             (clk),
    .i_regf_rst_n           (rst_n),
    .regf_bus               (bus.slave),
    .i_engine_configuration (cfg),
    .o_cccnt_CMD_ATTR       (cmd_attr),
    .o_engine_TID           (tid),
    .o_ccc_CMD              (cmd),
    .o_engine_CP            (cp),
    .o_cccnt_DEV_INDEX      (dev_index),
    .o_frmcnt_DTT           (dtt),
    .o_engine_MODE          (mode),
    .o_cccnt_RnW            (rnw),
    .o_cccnt_WROC           (wroc),
    .o_cccnt_TOC            (toc),
    .o_frmcnt_data_len      (data_len),
    .o_regf_num_frames      (num_frames)
  );

  always #10 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] model_mem [4096];
  logic [7:0] rd_q [$];
  logic [7:0] last_rd = 8'h00;
  dec_t       exp_now, exp_prev = '0, act;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference: whole 4 KiB address space as bytes; only the low 1 KiB ever stores data.
  function automatic dec_t model_decode();
    logic [7:0]  b [8];
    logic [31:0] w;
    dec_t        d;
    int          l;
    for (int k = 0; k < 8; k++) b[k] = model_mem[(int'(cfg) + k) % 4096];
    w = {b[3], b[2], b[1], b[0]};
    l = int'({b[7], b[6]});
    d.cmd_attr   = w[2:0];
    d.tid        = w[6:3];
    d.cmd        = w[14:7];
    d.cp         = w[15];
    d.dev_index  = w[20:16];
    d.dtt        = w[25:23];
    d.mode       = w[28:26];
    d.rnw        = w[29];
    d.wroc       = w[30];
    d.toc        = w[31];
    d.data_len   = 16'(l);
    d.num_frames = 16'((l + 1) / 2);
    return d;
  endfunction

  assign act = {cmd_attr, tid, cmd, cp, dev_index, dtt, mode, rnw, wroc, toc, data_len, num_frames};

  // Monitor: decodes every cycle, read data whenever the DUT flags a read response.
  always @(negedge clk) begin
    exp_now = model_decode();
    if (rst_n) begin
`ifdef REGF_DESC_LATCH_EN
      chk("decode", 64'(act), 64'(exp_prev));
`else
      chk("decode", 64'(act), 64'(exp_now));
`endif
      if (bus.ser_rx_tx) begin
        if (rd_q.size() == 0) chk("spurious_ser_rx_tx", 64'(bus.ser_rx_tx), 64'd0);
        else begin
          last_rd = rd_q.pop_front();
          chk("read_data", 64'(bus.data_rd), 64'(last_rd));
        end
      end else begin
        if (rd_q.size() != 0) begin
          chk("missing_ser_rx_tx", 64'(bus.ser_rx_tx), 64'd1);
          void'(rd_q.pop_front());
        end
        chk("data_rd_hold", 64'(bus.data_rd), 64'(last_rd));
      end
    end
    exp_prev = rst_n ? exp_now : '0;
  end

  task automatic op(input logic w, input logic r, input logic [11:0] a, input logic [7:0] d);
    bus.wr_en = w; bus.rd_en = r; bus.addr = a; bus.data_wr = d;
    @(posedge clk); #1;
    if (w && a < 12'd1024) model_mem[a] = d;
    if (r && !w) rd_q.push_back(model_mem[a]);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 12'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    rd_q.delete();
    last_rd = 8'h00;
    exp_prev = '0;
    #1;
    chk("rst_decode", 64'(act), 64'd0);
    chk("rst_data_rd", 64'(bus.data_rd), 64'd0);
    chk("rst_ser_rx_tx", 64'(bus.ser_rx_tx), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load_desc();
    op(1, 0, 12'd1000, 8'hF1); op(1, 0, 12'd1001, 8'h8F);
    op(1, 0, 12'd1002, 8'h10); op(1, 0, 12'd1003, 8'h18);
    op(1, 0, 12'd1006, 8'h05); op(1, 0, 12'd1007, 8'h00);
  endtask

  logic [11:0] ra;
  int          rsel;

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.data_wr = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    do_reset();
    op(0, 1, 12'd5, 8'd0);
    op(0, 1, 12'd1000, 8'd0);

    cfg = 12'd1000;
    load_desc();
    idle(2);
    chk("data_len", 64'(data_len), 64'd5);
    chk("num_frames", 64'(num_frames), 64'd3);
    chk("cmd_attr", 64'(cmd_attr), 64'd1);
    chk("tid", 64'(tid), 64'hE);
    chk("cmd", 64'(cmd), 64'h1F);
    chk("cp", 64'(cp), 64'd1);
    chk("dev_index", 64'(dev_index), 64'h10);
    chk("mode", 64'(mode), 64'd6);

    cfg = 12'd450;
    idle(2);
    chk("cfg450_decode", 64'(act), 64'd0);
    cfg = 12'd1000;
    idle(2);
    chk("cfg_back_cmd", 64'(cmd), 64'h1F);

    op(0, 1, 12'd1002, 8'd0);
    op(1, 1, 12'd1002, 8'h55);
    idle(1);
    op(0, 1, 12'd1002, 8'd0);
    op(1, 0, 12'd2000, 8'hAA);
    op(0, 1, 12'd2000, 8'd0);

    cfg = 12'd1020;
    for (int i = 0; i < 4; i++) op(1, 0, 12'(1020 + i), 8'($urandom_range(0, 255)));
    idle(2);
    chk("cfg1020_len", 64'(data_len), 64'd0);

    cfg = 12'd4092;
    op(1, 0, 12'd2, 8'hFF); op(1, 0, 12'd3, 8'hFF);
    idle(2);
    chk("wrap_len", 64'(data_len), 64'hFFFF);
    chk("wrap_frames", 64'(num_frames), 64'h8000);

    for (int i = 0; i < 500; i++) begin
      rsel = int'($urandom_range(0, 99));
      ra = (rsel < 75) ? 12'(1000 + $urandom_range(0, 31)) : 12'($urandom_range(0, 4095));
      if (rsel < 5) cfg = 12'(1000 + $urandom_range(0, 31));
      else if (rsel == 5) cfg = 12'($urandom_range(0, 4095));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)));
    end

    cfg = 12'd1000;
    load_desc();
    idle(2);
    do_reset();
    op(0, 1, 12'd1000, 8'd0);
    idle(2);
    chk("post_reset_decode", 64'(act), 64'd0);
    chk("queue_drained", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
